// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
package pipe_pkg;

  // Occupancy of the stage: EMPTY (nothing held), ONE (main only), TWO (main + skid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Distance from the PC+4 convention back to the instruction PC on flush.
  localparam int unsigned PC_REWIND = 4;

endpackage

// File: rtl/pipe_entry_reg.sv
// One {pc,data,ctrl} payload register with load enable and clear (clear wins).
module pipe_entry_reg #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   next_pc,
  input  logic [DATA_W-1:0] next_data,
  input  logic [CTRL_W-1:0] next_ctrl,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Payload storage: clear zeroes the entry, load captures the next payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= '0;
      data <= '0;
      ctrl <= '0;
    end else if (clear) begin
      pc   <= '0;
      data <= '0;
      ctrl <= '0;
    end else if (load) begin
      pc   <= next_pc;
      data <= next_data;
      ctrl <= next_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer and flush.
// Optional macro PIPE_STAGE_PERF_EN adds stall/flush performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned DATA_W      = 96,
  parameter int unsigned CTRL_W      = 32,
  parameter bit          BUBBLE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  state_t state;

  logic in_xfer;
  logic out_xfer;

  logic              main_load;
  logic [PC_W-1:0]   main_next_pc;
  logic [DATA_W-1:0] main_next_data;
  logic [CTRL_W-1:0] main_next_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;

  logic              skid_load;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Both handshake flags decode only the state flop, so in_ready has no path from out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Steer main/skid loads; flush turns the main load into a rewound-PC bubble.
  always_comb begin
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_next_pc   = in_pc;
    main_next_data = in_data;
    main_next_ctrl = in_ctrl;
    if (flush) begin
      main_load      = 1'b1;
      main_next_pc   = in_pc - PC_W'(PC_REWIND);
      main_next_data = '0;
      main_next_ctrl = '0;
    end else begin
      case (state)
        EMPTY: main_load = in_xfer;
        ONE: begin
          if (in_xfer && out_xfer) main_load = 1'b1;
          else if (in_xfer)        skid_load = 1'b1;
        end
        TWO: begin
          if (out_xfer) begin
            main_load      = 1'b1;
            main_next_pc   = skid_pc;
            main_next_data = skid_data;
            main_next_ctrl = skid_ctrl;
          end
        end
        default: ;
      endcase
    end
  end

  // Occupancy state machine; flush empties the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) state <= ONE;
        ONE: begin
          if (in_xfer && !out_xfer)      state <= TWO;
          else if (!in_xfer && out_xfer) state <= EMPTY;
        end
        TWO:     if (out_xfer) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (1'b0),
    .next_pc   (main_next_pc),
    .next_data (main_next_data),
    .next_ctrl (main_next_ctrl),
    .pc        (out_pc),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  pipe_entry_reg #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (flush),
    .next_pc   (in_pc),
    .next_data (in_data),
    .next_ctrl (in_ctrl),
    .pc        (skid_pc),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

  // Drained main entry keeps its payload; masking here realises bubble-zero without extra loads.
  assign out_data = (BUBBLE_ZERO && !out_valid) ? '0 : main_data;
  assign out_ctrl = (BUBBLE_ZERO && !out_valid) ? '0 : main_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  logic flush_kill;
  assign flush_kill = flush & (out_valid | (state == TWO) | in_valid);

  // Saturating counters for upstream stalls and flushes that discarded work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_kill && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (default parameters).
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [95:0] in_data;
  logic [31:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [95:0] out_data;
  logic [31:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int unsigned total;
  int unsigned bad;

  pipe_stage_skid #(
    .PC_W        (32),
    .DATA_W      (96),
    .CTRL_W      (32),
    .BUBBLE_ZERO (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] data_of(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h5A5A_5A5A};
  endfunction

  function automatic logic [31:0] ctrl_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_data  = data_of(pc);
    in_ctrl  = ctrl_of(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_pc"},    out_pc,    pc);
    chk({tag, "_data"},  out_data,  data_of(pc));
    chk({tag, "_ctrl"},  out_ctrl,  ctrl_of(pc));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready,  1'b1);
    chk("rst_pc",    out_pc,    32'h0);
    chk("rst_data",  out_data,  96'h0);
    chk("rst_ctrl",  out_ctrl,  32'h0);
    reset = 1'b0;

    // Streaming at full rate, 1-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h100);
    tick;
    chk_entry("s0", 32'h100);
    chk("s0_ready", in_ready, 1'b1);
    drive(1'b1, 32'h104);
    tick;
    chk_entry("s1", 32'h104);
    drive(1'b1, 32'h108);
    tick;
    chk_entry("s2", 32'h108);
    drive(1'b0, 32'h10C);
    tick;
    chk("s3_valid", out_valid, 1'b0);
    chk("s3_pc",    out_pc,    32'h108);
    chk("s3_data",  out_data,  96'h0);
    chk("s3_ctrl",  out_ctrl,  32'h0);

    // Back-pressure: two accepts fill main + skid
    out_ready = 1'b0;
    drive(1'b1, 32'h200);
    tick;
    chk_entry("bp0", 32'h200);
    chk("bp0_ready", in_ready, 1'b1);
    drive(1'b1, 32'h204);
    tick;
    chk("bp1_ready", in_ready, 1'b0);
    chk_entry("bp1", 32'h200);
    drive(1'b0, 32'h208);
    tick;
    chk("bp2_ready", in_ready, 1'b0);
    chk_entry("bp2", 32'h200);
    out_ready = 1'b1;
    tick;
    chk_entry("bp3", 32'h204);
    chk("bp3_ready", in_ready, 1'b1);
    tick;
    chk("bp4_valid", out_valid, 1'b0);

    // Flush in TWO state
    out_ready = 1'b0;
    drive(1'b1, 32'h300);
    tick;
    drive(1'b1, 32'h304);
    tick;
    chk("fl_pre_ready", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h404);
    tick;
    flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ctrl",  out_ctrl,  32'h0);
    chk("fl_data",  out_data,  96'h0);
    chk("fl_pc",    out_pc,    32'h400);
    chk("fl_ready", in_ready,  1'b1);
    out_ready = 1'b1;
    tick;
    chk("fl_post_valid", out_valid, 1'b0);
    chk("fl_post_pc",    out_pc,    32'h400);

    // Flush PC wraps below zero
    flush = 1'b1;
    drive(1'b0, 32'h0);
    tick;
    flush = 1'b0;
    chk("wrap_pc",    out_pc,    32'hFFFF_FFFC);
    chk("wrap_valid", out_valid, 1'b0);

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    drive(1'b1, 32'h500);
    tick;
    drive(1'b1, 32'h504);
    tick;
    drive(1'b0, 32'h0);
    chk("ar_pre_ready", in_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_ready", in_ready,  1'b1);
    chk("ar_ctrl",  out_ctrl,  32'h0);
    chk("ar_pc",    out_pc,    32'h0);
    tick;
    reset     = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("ar_post_valid", out_valid, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    // Performance counters: 5 stalled cycles, then 2 killing flushes
    chk("perf_stall0", perf_stall_cnt, 32'd0);
    chk("perf_flush0", perf_flush_cnt, 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h600);
    tick;
    drive(1'b1, 32'h604);
    tick;
    drive(1'b1, 32'h608);
    repeat (5) tick;
    chk("perf_stall5", perf_stall_cnt, 32'd5);
    flush = 1'b1;
    drive(1'b0, 32'h700);
    tick;
    drive(1'b1, 32'h704);
    tick;
    flush = 1'b0;
    drive(1'b0, 32'h0);
    tick;
    chk("perf_stall", perf_stall_cnt, 32'd5);
    chk("perf_flush", perf_flush_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
